// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl
//   Lookup sequencer for a 4-way, 256-set cache tag array (tag_blockram).
//   It accepts one lookup at a time and drives the read index. It compares
//   the four returned tags against the captured request tag and reports
//   either hit/way or miss/victim way. On fill_valid it installs the tag.
//   It owns the per-line valid bits and the replacement state.
//
//   Optional build macro: PLRU_EN
//     defined   : 3-bit tree pseudo-LRU per set
//     undefined : one 2-bit global round-robin counter
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     lookup handshake; req_addr = {tag, idx, off}
//   resp_valid              1-cycle result pulse
//   resp_hit, resp_way      hit flag; hit way on a hit, victim way on a miss
//   fill_valid / fill_done  line delivered for the outstanding miss / tag installed
//   flush                   invalidate every line (honoured in IDLE only)
//   busy                    controller not idle
//   r_index                 tag array read index (array read is registered)
//   w_index, tag_in, wr_en  tag array write port, w_index = {set, way}
//   tag_out                 tag array read data, way w at [w*TAG_W +: TAG_W]
module tag_lookup_ctrl #(
    parameter int TAG_W = 18,
    parameter int IDX_W = 8,
    parameter int OFF_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TAG_W+IDX_W+OFF_W-1:0] req_addr,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [1:0]               resp_way,
    input  logic                     fill_valid,
    output logic                     fill_done,
    input  logic                     flush,
    output logic                     busy,
    output logic [IDX_W-1:0]         r_index,
    output logic [IDX_W+1:0]         w_index,
    output logic [TAG_W-1:0]         tag_in,
    output logic                     wr_en,
    input  logic [4*TAG_W-1:0]       tag_out
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, CMP, FILL_WAIT} state_t;

    state_t                   state_q;
    logic [4*SETS-1:0]        valid_q;
    logic [TAG_W+IDX_W-1:0]   cap_line_q;   // captured {tag, idx}; the offset is never needed
    logic [1:0]               victim_q;

`ifdef PLRU_EN
    logic [2:0]               plru_q [SETS];
`else
    logic [1:0]               rr_q;
`endif

    logic [TAG_W-1:0]         cap_tag;
    logic [IDX_W-1:0]         cap_idx;
    logic [3:0]               set_valid;
    logic                     hit_any, inv_any;
    logic [1:0]               hit_way, inv_way, repl_way, victim;
    logic                     unused_off;

    assign cap_tag    = cap_line_q[IDX_W +: TAG_W];
    assign cap_idx    = cap_line_q[IDX_W-1:0];
    assign unused_off = ^req_addr[OFF_W-1:0];

`ifdef PLRU_EN
    // Mark way w most recently used. Each tree bit is set to point at the other side.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n    = p;
        n[0] = ~w[1];
        if (!w[1]) n[1] = ~w[0];
        else       n[2] = ~w[0];
        return n;
    endfunction
`endif

    always_comb begin
        set_valid = valid_q[{cap_idx, 2'b00} +: 4];
        hit_any   = 1'b0;
        hit_way   = 2'd0;
        inv_any   = 1'b0;
        inv_way   = 2'd0;
        // The lowest way takes priority for both the hit search and the invalid-way search.
        for (int unsigned w = 0; w < 4; w++) begin
            if (!hit_any && set_valid[w] && (tag_out[w*TAG_W +: TAG_W] == cap_tag)) begin
                hit_any = 1'b1;
                hit_way = w[1:0];
            end
            if (!inv_any && !set_valid[w]) begin
                inv_any = 1'b1;
                inv_way = w[1:0];
            end
        end
`ifdef PLRU_EN
        repl_way = plru_q[cap_idx][0] ? {1'b1, plru_q[cap_idx][2]}
                                      : {1'b0, plru_q[cap_idx][1]};
`else
        repl_way = rr_q;
`endif
        victim = inv_any ? inv_way : repl_way;
    end

    always_comb begin
        req_ready  = rst_n && (state_q == IDLE) && !flush;
        r_index    = (state_q == IDLE) ? req_addr[OFF_W +: IDX_W] : cap_idx;
        resp_valid = (state_q == CMP);
        resp_hit   = (state_q == CMP) && hit_any;
        resp_way   = (state_q == CMP) ? (hit_any ? hit_way : victim) : 2'd0;
        wr_en      = (state_q == FILL_WAIT) && fill_valid;
        fill_done  = wr_en;
        w_index    = wr_en ? {cap_idx, victim_q} : '0;
        tag_in     = wr_en ? cap_tag : '0;
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            cap_line_q <= '0;
            victim_q   <= 2'd0;
`ifdef PLRU_EN
            for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
`else
            rr_q       <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
`ifdef PLRU_EN
                        for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
`else
                        rr_q    <= 2'd0;
`endif
                    end else if (req_valid) begin
                        cap_line_q <= req_addr[OFF_W +: TAG_W+IDX_W];
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    if (hit_any) begin
`ifdef PLRU_EN
                        plru_q[cap_idx] <= plru_touch(plru_q[cap_idx], hit_way);
`endif
                        state_q <= IDLE;
                    end else begin
                        victim_q <= victim;
`ifndef PLRU_EN
                        // The counter advances only when it actually chose the victim.
                        if (!inv_any) rr_q <= rr_q + 2'd1;
`endif
                        state_q  <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fill_valid) begin
                        valid_q[{cap_idx, victim_q}] <= 1'b1;
`ifdef PLRU_EN
                        plru_q[cap_idx] <= plru_touch(plru_q[cap_idx], victim_q);
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed testbench for tag_lookup_ctrl. It includes a behavioural
// registered-read tag array (tag_blockram).
module tb_tag_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_hit;
    logic [1:0]  resp_way;
    logic        fill_valid, fill_done, flush, busy;
    logic [7:0]  r_index;
    logic [9:0]  w_index;
    logic [17:0] tag_in;
    logic        wr_en;
    logic [71:0] tag_out;

    logic [17:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    logic [31:0] hist_addr [8];
    logic [1:0]  hist_way  [8];

    tag_lookup_ctrl #(.TAG_W(18), .IDX_W(8), .OFF_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .fill_valid(fill_valid), .fill_done(fill_done), .flush(flush), .busy(busy),
        .r_index(r_index), .w_index(w_index), .tag_in(tag_in), .wr_en(wr_en),
        .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    // Tag array: synchronous write, registered read of all four ways.
    always @(posedge clk) begin
        if (wr_en) mem[w_index] <= tag_in;
        tag_out <= {mem[{r_index, 2'd3}], mem[{r_index, 2'd2}],
                    mem[{r_index, 2'd1}], mem[{r_index, 2'd0}]};
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Starts and ends at a negedge with the controller idle. A miss is followed by a fill.
    task automatic access(input logic [31:0] a, input logic exp_hit, input logic [1:0] exp_way,
                          input string nm);
        logic [7:0]  idx;
        logic [17:0] tg;
        idx = a[13:6];
        tg  = a[31:14];
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk({nm, " req_ready"}, req_ready, 1);
        chk({nm, " r_index"}, r_index, idx);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, " resp_valid"}, resp_valid, 1);
        chk({nm, " resp_hit"}, resp_hit, exp_hit);
        chk({nm, " resp_way"}, resp_way, exp_way);
        chk({nm, " wr_en in cmp"}, wr_en, 0);
        @(negedge clk);
        if (exp_hit) begin
            chk({nm, " busy after hit"}, busy, 0);
        end else begin
            chk({nm, " busy fill_wait"}, busy, 1);
            chk({nm, " resp_valid fill_wait"}, resp_valid, 0);
            chk({nm, " wr_en idle wait"}, wr_en, 0);
            fill_valid = 1'b1;
            #1;
            chk({nm, " wr_en"}, wr_en, 1);
            chk({nm, " w_index"}, w_index, {idx, exp_way});
            chk({nm, " tag_in"}, tag_in, tg);
            chk({nm, " fill_done"}, fill_done, 1);
            @(negedge clk);
            fill_valid = 1'b0;
            chk({nm, " busy after fill"}, busy, 0);
        end
    endtask

    initial begin
        logic [1:0] v5, v6;
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; fill_valid = 1'b0; flush = 1'b0;

        @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("reset req_ready", req_ready, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset resp_hit", resp_hit, 0);
        chk("reset resp_way", resp_way, 0);
        chk("reset fill_done", fill_done, 0);
        chk("reset wr_en", wr_en, 0);
        chk("reset busy", busy, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First lookup misses into way 0, then a repeat lookup hits.
        access(32'h0000_4040, 1'b0, 2'd0, "first miss");
        access(32'h0000_4040, 1'b1, 2'd0, "first hit");

        // Fill set 0x01 completely, hit ways 1..3, then evict.
        access(32'h0000_8040, 1'b0, 2'd1, "set1 tag2");
        access(32'h0000_C040, 1'b0, 2'd2, "set1 tag3");
        access(32'h0001_0040, 1'b0, 2'd3, "set1 tag4");
        access(32'h0000_8040, 1'b1, 2'd1, "hit tag2");
        access(32'h0000_C040, 1'b1, 2'd2, "hit tag3");
        access(32'h0001_0040, 1'b1, 2'd3, "hit tag4");
`ifdef PLRU_EN
        v5 = 2'd0; v6 = 2'd2;
`else
        v5 = 2'd0; v6 = 2'd1;
`endif
        access(32'h0001_4040, 1'b0, v5, "evict tag5");
        access(32'h0001_8040, 1'b0, v6, "evict tag6");
        access(32'h0001_0040, 1'b1, 2'd3, "tag4 survives");

        // A flush takes priority over a request in the same cycle.
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0001_0040;
        #1;
        chk("flush req_ready", req_ready, 0);
        @(negedge clk);
        chk("flush not accepted busy", busy, 0);
        chk("flush no resp", resp_valid, 0);
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        access(32'h0001_0040, 1'b0, 2'd0, "after flush");

        // Reset while in FILL_WAIT drops the fill and invalidates every line.
        access(32'h0000_4080, 1'b0, 2'd0, "set2 tag1");
        req_valid = 1'b1; req_addr = 32'h0000_40C0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre-reset miss", resp_hit, 0);
        @(negedge clk);
        chk("pre-reset fill_wait busy", busy, 1);
        rst_n = 1'b0; fill_valid = 1'b1;
        #1;
        chk("reset in fill wr_en", wr_en, 0);
        chk("reset in fill busy", busy, 0);
        chk("reset in fill fill_done", fill_done, 0);
        @(negedge clk);
        rst_n = 1'b1; fill_valid = 1'b0;
        @(negedge clk);
        access(32'h0001_0040, 1'b0, 2'd0, "post-reset set1");
        access(32'h0000_4080, 1'b0, 2'd0, "post-reset set2");
        access(32'h0000_40C0, 1'b0, 2'd0, "post-reset set3");

        // Fill set 0x05 with tags 0x10..0x13 in ways 0..3.
        for (int t = 0; t < 4; t++) begin
            hist_addr[t] = (32'(t + 16) << 14) | 32'h0000_0140;
            hist_way[t]  = 2'(t);
            access(hist_addr[t], 1'b0, hist_way[t], "set5 fill");
        end
        hist_addr[4] = 32'h0001_0040; hist_way[4] = 2'd0;
        hist_addr[5] = 32'h0000_4080; hist_way[5] = 2'd0;
        hist_addr[6] = 32'h0000_40C0; hist_way[6] = 2'd0;
        hist_addr[7] = (32'd17 << 14) | 32'h0000_0140; hist_way[7] = 2'd1;

        // Back-to-back hits with req_valid held high.
        req_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            k = int'($urandom_range(0, 7));
            req_addr = hist_addr[k];
            #1;
            chk("b2b req_ready", req_ready, 1);
            @(posedge clk);
            @(negedge clk);
            chk("b2b resp_valid", resp_valid, 1);
            chk("b2b resp_hit", resp_hit, 1);
            chk("b2b resp_way", resp_way, hist_way[k]);
            @(negedge clk);
            chk("b2b idle gap", resp_valid, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
